// File: rtl/cc_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cc_bus_arbiter_pkg
// Shared definitions for the round-robin bus arbiter:
//   - cc_arb_state_t : arbiter FSM state encoding (IDLE=0, GRANTED=1)
//   - CC_SEL_W       : default selection width
//   - CC_N           : default requester count (2**CC_SEL_W)
//   - CC_MAX_HOLD    : default maximum tenure in cycles (timeout build only)
// -----------------------------------------------------------------------------
package cc_bus_arbiter_pkg;

    localparam int CC_SEL_W    = 3;
    localparam int CC_N        = 2 ** CC_SEL_W;
    localparam int CC_MAX_HOLD = 16;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_GRANTED = 1'b1
    } cc_arb_state_t;

endpackage : cc_bus_arbiter_pkg

// File: rtl/cc_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// cc_bus_arbiter_if
// Request/grant bundle between the requesters and the arbiter.
//   CC_ARB_request_InBUS    [N]  level-held request per requester
//   CC_ARB_release_InBUS    [N]  one-cycle release pulse per requester
//   CC_ARB_grant_OutBUS     [N]  registered one-hot grant
//   CC_ARB_selection_OutBUS [W]  registered owner index (datapath mux select)
//   CC_ARB_busy_Out              high while a grant is active
//   CC_ARB_timeout_Out           one-cycle pulse on forced release
// Modports:
//   master : requester side (drives request/release, observes grant)
//   slave  : arbiter side   (observes request/release, drives grant)
// -----------------------------------------------------------------------------
interface cc_bus_arbiter_if
    import cc_bus_arbiter_pkg::*;
#(
    parameter int DATAWIDTH_MUX_SELECTION = CC_SEL_W
);
    localparam int N = 2 ** DATAWIDTH_MUX_SELECTION;

    logic [N-1:0]                       CC_ARB_request_InBUS;
    logic [N-1:0]                       CC_ARB_release_InBUS;
    logic [N-1:0]                       CC_ARB_grant_OutBUS;
    logic [DATAWIDTH_MUX_SELECTION-1:0] CC_ARB_selection_OutBUS;
    logic                               CC_ARB_busy_Out;
    logic                               CC_ARB_timeout_Out;

    modport master (
        output CC_ARB_request_InBUS,
        output CC_ARB_release_InBUS,
        input  CC_ARB_grant_OutBUS,
        input  CC_ARB_selection_OutBUS,
        input  CC_ARB_busy_Out,
        input  CC_ARB_timeout_Out
    );

    modport slave (
        input  CC_ARB_request_InBUS,
        input  CC_ARB_release_InBUS,
        output CC_ARB_grant_OutBUS,
        output CC_ARB_selection_OutBUS,
        output CC_ARB_busy_Out,
        output CC_ARB_timeout_Out
    );

endinterface : cc_bus_arbiter_if

// File: rtl/cc_rr_priority.sv
// -----------------------------------------------------------------------------
// cc_rr_priority
// Combinational round-robin winner search. Scans upward from last_owner+1,
// wrapping modulo N, so last_owner itself is checked last (lowest priority).
// Ports:
//   request    [N]      in   request vector
//   last_owner [SEL_W]  in   index of the previous owner
//   found               out  at least one request bit is set
//   winner     [SEL_W]  out  index of the chosen requester (last_owner if none)
// -----------------------------------------------------------------------------
module cc_rr_priority
    import cc_bus_arbiter_pkg::*;
#(
    parameter int SEL_W = CC_SEL_W
) (
    input  logic [2**SEL_W-1:0] request,
    input  logic [SEL_W-1:0]    last_owner,
    output logic                found,
    output logic [SEL_W-1:0]    winner
);
    localparam int N = 2 ** SEL_W;

    logic [SEL_W-1:0] idx;

    // Walk from the farthest offset down to the nearest so the closest
    // requester after last_owner is the one left in winner. Offset N wraps
    // to last_owner itself, giving it the lowest priority.
    always_comb begin
        found  = 1'b0;
        winner = last_owner;
        idx    = last_owner;
        for (int i = N; i >= 1; i--) begin
            idx = last_owner + SEL_W'(i);
            if (request[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule : cc_rr_priority

// File: rtl/cc_bus_arbiter.sv
// -----------------------------------------------------------------------------
// cc_bus_arbiter
// Round-robin arbiter for N = 2**DATAWIDTH_MUX_SELECTION requesters sharing
// one bus. Two-state FSM (IDLE / GRANTED) with registered one-hot grant and
// owner index; tenure ends on release or request drop by the owner and the
// next owner is granted on the same edge when others are waiting.
//
// Optional build macro CC_BUS_ARBITER_TIMEOUT_EN: adds a hold counter that
// forces the owner off the bus after MAX_HOLD granted cycles and pulses
// CC_ARB_timeout_Out. Without it tenure is unbounded and timeout is tied 0.
//
// Ports:
//   CC_ARB_CLOCK_50     in  system clock, rising edge
//   CC_ARB_RESET_InLow  in  asynchronous active-low reset
//   bus                 cc_bus_arbiter_if.slave (request/release in,
//                       grant/selection/busy/timeout out)
// -----------------------------------------------------------------------------
module cc_bus_arbiter
    import cc_bus_arbiter_pkg::*;
#(
    parameter int DATAWIDTH_MUX_SELECTION = CC_SEL_W,
    parameter int MAX_HOLD                = CC_MAX_HOLD
) (
    input  logic             CC_ARB_CLOCK_50,
    input  logic             CC_ARB_RESET_InLow,
    cc_bus_arbiter_if.slave  bus
);
    localparam int W = DATAWIDTH_MUX_SELECTION;
    localparam int N = 2 ** W;

    cc_arb_state_t state_q, state_next;
    logic [N-1:0]  grant_q, grant_next;
    logic [W-1:0]  sel_q, sel_next;
    logic [W-1:0]  last_owner_q, last_owner_next;
    logic          busy_q, busy_next;

    logic          new_grant;
    logic          tenure_end;
    logic          timeout_hit;
    logic          found;
    logic [W-1:0]  winner;

    function automatic logic [N-1:0] to_onehot(input logic [W-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    cc_rr_priority #(
        .SEL_W      (W)
    ) u_rr (
        .request    (bus.CC_ARB_request_InBUS),
        .last_owner (last_owner_q),
        .found      (found),
        .winner     (winner)
    );

    // Next-state and next-output logic. While GRANTED, sel_q always holds the
    // current owner, so it indexes the owner's request/release bits directly;
    // bits of non-owners never reach the tenure decision.
    always_comb begin
        state_next      = state_q;
        grant_next      = grant_q;
        sel_next        = sel_q;
        last_owner_next = last_owner_q;
        busy_next       = busy_q;
        new_grant       = 1'b0;
        tenure_end      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    new_grant = 1'b1;
                end
            end
            ST_GRANTED: begin
                tenure_end = bus.CC_ARB_release_InBUS[sel_q]
                           | ~bus.CC_ARB_request_InBUS[sel_q]
                           | timeout_hit;
                if (tenure_end) begin
                    // The owner is the lowest-priority candidate, so it is
                    // re-chosen only when nobody else is requesting.
                    if (found) begin
                        new_grant = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                        grant_next = '0;
                        busy_next  = 1'b0;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                grant_next = '0;
                busy_next  = 1'b0;
            end
        endcase

        if (new_grant) begin
            state_next      = ST_GRANTED;
            grant_next      = to_onehot(winner);
            sel_next        = winner;
            last_owner_next = winner;
            busy_next       = 1'b1;
        end
    end

    // last_owner resets to N-1 so the first search starts at index 0.
    always_ff @(posedge CC_ARB_CLOCK_50 or negedge CC_ARB_RESET_InLow) begin
        if (!CC_ARB_RESET_InLow) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            sel_q        <= '0;
            last_owner_q <= W'(N - 1);
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_next;
            grant_q      <= grant_next;
            sel_q        <= sel_next;
            last_owner_q <= last_owner_next;
            busy_q       <= busy_next;
        end
    end

`ifdef CC_BUS_ARBITER_TIMEOUT_EN
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [HOLD_W-1:0] hold_cnt_q;
    logic              timeout_q;

    // The counter reads k-1 during the k-th granted cycle, so reaching
    // MAX_HOLD-1 means this edge closes the MAX_HOLD-th cycle of tenure.
    assign timeout_hit = (state_q == ST_GRANTED)
                       && (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));

    always_ff @(posedge CC_ARB_CLOCK_50 or negedge CC_ARB_RESET_InLow) begin
        if (!CC_ARB_RESET_InLow) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= timeout_hit;
            if (new_grant) begin
                hold_cnt_q <= '0;
            end else if (state_q == ST_GRANTED) begin
                hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
            end
        end
    end

    assign bus.CC_ARB_timeout_Out = timeout_q;
`else
    assign timeout_hit            = 1'b0;
    assign bus.CC_ARB_timeout_Out = 1'b0;
`endif

    assign bus.CC_ARB_grant_OutBUS     = grant_q;
    assign bus.CC_ARB_selection_OutBUS = sel_q;
    assign bus.CC_ARB_busy_Out         = busy_q;

endmodule : cc_bus_arbiter

// File: tb/tb_cc_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cc_bus_arbiter
// Self-checking bench for cc_bus_arbiter (8 requesters). A table of
// per-cycle {request, release, expected outputs} records is driven on the
// falling edge; each record is queued as the expectation and popped and
// compared just after the following rising edge. Hand-written sequences
// cover long tenure (timeout when CC_BUS_ARBITER_TIMEOUT_EN is defined) and
// reset asserted mid-tenure.
// -----------------------------------------------------------------------------
module tb_cc_bus_arbiter;
    import cc_bus_arbiter_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    cc_bus_arbiter_if #(.DATAWIDTH_MUX_SELECTION(3)) bus ();

    cc_bus_arbiter #(
        .DATAWIDTH_MUX_SELECTION (3),
        .MAX_HOLD                (16)
    ) dut (
        .CC_ARB_CLOCK_50    (clk),
        .CC_ARB_RESET_InLow (rst_n),
        .bus                (bus.slave)
    );

    typedef struct {
        logic [7:0] req;
        logic [7:0] rel;
        logic [7:0] grant;
        logic [2:0] sel;
        logic       busy;
        logic       tmo;
    } vec_t;

    localparam int NVEC = 19;

    vec_t tbl [NVEC];
    vec_t sb_q [$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic [7:0] req, input logic [7:0] rel,
                                input logic [7:0] grant, input logic [2:0] sel,
                                input logic busy, input logic tmo);
        vec_t v;
        v.req   = req;
        v.rel   = rel;
        v.grant = grant;
        v.sel   = sel;
        v.busy  = busy;
        v.tmo   = tmo;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic compare_out(input string tag);
        vec_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: no expectation queued, got grant 0x%0h", tag,
                     bus.CC_ARB_grant_OutBUS);
            return;
        end
        e = sb_q.pop_front();
        check({tag, ".grant"}, 32'(bus.CC_ARB_grant_OutBUS), 32'(e.grant));
        check({tag, ".sel"},   32'(bus.CC_ARB_selection_OutBUS), 32'(e.sel));
        check({tag, ".busy"},  32'(bus.CC_ARB_busy_Out), 32'(e.busy));
        check({tag, ".tmo"},   32'(bus.CC_ARB_timeout_Out), 32'(e.tmo));
    endtask

    // One clock of stimulus: drive on the falling edge, sample 1ns after the
    // rising edge that acts on it.
    task automatic step(input vec_t v, input string tag);
        @(negedge clk);
        bus.CC_ARB_request_InBUS = v.req;
        bus.CC_ARB_release_InBUS = v.rel;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.CC_ARB_request_InBUS = '0;
        bus.CC_ARB_release_InBUS = '0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.CC_ARB_request_InBUS = '0;
        bus.CC_ARB_release_InBUS = '0;

        //           req    rel    grant  sel busy tmo
        tbl[0]  = mk(8'h01, 8'h00, 8'h01, 0, 1, 0); // first grant from reset
        tbl[1]  = mk(8'h85, 8'h01, 8'h04, 2, 1, 0); // owner 0 releases -> 2
        tbl[2]  = mk(8'h85, 8'h04, 8'h80, 7, 1, 0); // owner 2 releases -> 7
        tbl[3]  = mk(8'h85, 8'h80, 8'h01, 0, 1, 0); // wrap to 0
        tbl[4]  = mk(8'h85, 8'h00, 8'h01, 0, 1, 0); // hold
        tbl[5]  = mk(8'h84, 8'h00, 8'h04, 2, 1, 0); // owner 0 drops -> 2
        tbl[6]  = mk(8'h80, 8'h00, 8'h80, 7, 1, 0); // owner 2 drops -> 7
        tbl[7]  = mk(8'h80, 8'h80, 8'h80, 7, 1, 0); // sole requester re-granted
        tbl[8]  = mk(8'h88, 8'h80, 8'h08, 3, 1, 0); // release with other -> 3
        tbl[9]  = mk(8'h28, 8'h20, 8'h08, 3, 1, 0); // non-owner release ignored
        tbl[10] = mk(8'h20, 8'h00, 8'h20, 5, 1, 0); // owner 3 drops -> 5
        tbl[11] = mk(8'h30, 8'h00, 8'h20, 5, 1, 0); // hold with 4 waiting
        tbl[12] = mk(8'h10, 8'h00, 8'h10, 4, 1, 0); // owner 5 drops -> 4
        tbl[13] = mk(8'h10, 8'h00, 8'h10, 4, 1, 0); // hold
        tbl[14] = mk(8'h00, 8'h00, 8'h00, 4, 0, 0); // to IDLE, sel kept
        tbl[15] = mk(8'h00, 8'h00, 8'h00, 4, 0, 0); // stays IDLE
        tbl[16] = mk(8'h0C, 8'h00, 8'h04, 2, 1, 0); // search from 5 wraps to 2
        tbl[17] = mk(8'h0C, 8'h08, 8'h04, 2, 1, 0); // non-owner release ignored
        tbl[18] = mk(8'hFF, 8'h04, 8'h08, 3, 1, 0); // all request -> next is 3

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset.grant", 32'(bus.CC_ARB_grant_OutBUS), 32'h0);
        check("reset.sel",   32'(bus.CC_ARB_selection_OutBUS), 32'h0);
        check("reset.busy",  32'(bus.CC_ARB_busy_Out), 32'h0);
        check("reset.tmo",   32'(bus.CC_ARB_timeout_Out), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Long tenure: requesters 1 and 6, owner 1 never releases
        do_reset();
        step(mk(8'h42, 8'h00, 8'h02, 1, 1, 0), "hold0");
`ifdef CC_BUS_ARBITER_TIMEOUT_EN
        for (int k = 1; k < 16; k++) begin
            step(mk(8'h42, 8'h00, 8'h02, 1, 1, 0), $sformatf("hold%0d", k));
        end
        step(mk(8'h42, 8'h00, 8'h40, 6, 1, 1), "timeout");
        step(mk(8'h42, 8'h00, 8'h40, 6, 1, 0), "after_timeout");
`else
        for (int k = 1; k <= 100; k++) begin
            step(mk(8'h42, 8'h00, 8'h02, 1, 1, 0), $sformatf("hold%0d", k));
        end
`endif

        // Reset asserted between edges while a grant is active
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.grant", 32'(bus.CC_ARB_grant_OutBUS), 32'h0);
        check("midrst.sel",   32'(bus.CC_ARB_selection_OutBUS), 32'h0);
        check("midrst.busy",  32'(bus.CC_ARB_busy_Out), 32'h0);
        bus.CC_ARB_request_InBUS = 8'hFF;
        bus.CC_ARB_release_InBUS = 8'h00;
        @(posedge clk);
        #1;
        check("inrst.grant", 32'(bus.CC_ARB_grant_OutBUS), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(mk(8'hFF, 8'h00, 8'h01, 0, 1, 0), "post_reset");
        step(mk(8'hFF, 8'h01, 8'h02, 1, 1, 0), "post_reset_next");

        check("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_cc_bus_arbiter
